lifo_stack: RTL and testbench

Parametrised single-clock hardware LIFO for return-address and operand storage in the processor datapath. Supports push, pop and simultaneous push+pop (replace top), exposes the top-of-stack word and occupancy every cycle, and reports overflow/underflow as sticky flags with explicit clear. It is the successor to the fixed 32x10 dual-clock stack, with configurable width and depth, an optional zero-push filter and defined behaviour for every corner case.

---
 rtl/lifo_stack_pkg.sv | 17 +
 rtl/lifo_stack_if.sv | 30 +++
 rtl/lifo_stack_mem.sv | 22 ++
 rtl/lifo_stack.sv | 99 +++++++++
 tb/tb_lifo_stack.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: width helper and the control opcode encoding.
package lifo_pkg;

    // Opcode is {pop, push_eff}, so the encoding falls straight out of the request bits.
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/status bundle between a stack user (master) and the LIFO (slave).
interface lifo_stack_if
    import lifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] dado;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] saida;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovrflw;
    logic             undrflw;

    modport master (
        output dado, push, pop, clr_err,
        input  saida, count, full, empty, ovrflw, undrflw
    );

    modport slave (
        input  dado, push, pop, clr_err,
        output saida, count, full, empty, ovrflw, undrflw
    );
endinterface

// File: rtl/lifo_stack_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module lifo_stack_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the count register, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_stack.sv
// Parametrised single-clock LIFO: count register, op decode, sticky error flags and top-of-stack mux.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 10,
    parameter int IGNORE_ZERO = 0
) (
    input logic         clk,
    input logic         rst_n,
    lifo_stack_if.slave bus
);
    localparam int CW = clog2(DEPTH + 1);
    localparam int AW = clog2(DEPTH);

    logic [CW-1:0]    count_q;
    logic             ovrflw_q;
    logic             undrflw_q;
    logic             push_eff;
    logic [1:0]       op;
    logic             is_full;
    logic             is_empty;
    logic             we;
    logic [CW-1:0]    waddr;
    logic [CW-1:0]    top_idx;
    logic [WIDTH-1:0] rdata;

    assign push_eff = bus.push && !((IGNORE_ZERO != 0) && (bus.dado == '0));
    assign op       = {bus.pop, push_eff};
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign top_idx  = count_q - CW'(1);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = count_q;
        case (op)
            OP_PUSH: we = !is_full;
            OP_REPL: begin
                we    = 1'b1;
                waddr = is_empty ? '0 : top_idx;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments; the clear comes first so a same-cycle error overrides it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            ovrflw_q  <= 1'b0;
            undrflw_q <= 1'b0;
        end else begin
            if (bus.clr_err) begin
                ovrflw_q  <= 1'b0;
                undrflw_q <= 1'b0;
            end
            case (op)
                OP_PUSH: begin
                    if (is_full) ovrflw_q <= 1'b1;
                    else         count_q  <= count_q + CW'(1);
                end
                OP_POP: begin
                    if (is_empty) undrflw_q <= 1'b1;
                    else          count_q   <= top_idx;
                end
                OP_REPL: begin
                    // Replace on an empty stack degenerates to a push plus an underflow report.
                    if (is_empty) begin
                        count_q   <= CW'(1);
                        undrflw_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    lifo_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr[AW-1:0]),
        .wdata (bus.dado),
        .raddr (top_idx[AW-1:0]),
        .rdata (rdata)
    );

    assign bus.saida   = is_empty ? '0 : rdata;
    assign bus.count   = count_q;
    assign bus.full    = is_full;
    assign bus.empty   = is_empty;
    assign bus.ovrflw  = ovrflw_q;
    assign bus.undrflw = undrflw_q;
endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed corner cases plus a randomized soak against a queue model.
module tb_lifo_stack;
    logic        clk;
    logic        rst_n;
    logic [31:0] dado;
    logic        push;
    logic        pop;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    lifo_stack_if #(.WIDTH(32), .DEPTH(4))  b4  ();
    lifo_stack_if #(.WIDTH(32), .DEPTH(4))  b4z ();
    lifo_stack_if #(.WIDTH(32), .DEPTH(2))  b2  ();
    lifo_stack_if #(.WIDTH(32), .DEPTH(10)) b10 ();
    lifo_stack_if #(.WIDTH(32), .DEPTH(16)) b16 ();

    assign b4.dado  = dado;  assign b4.push  = push;  assign b4.pop  = pop;  assign b4.clr_err  = clr_err;
    assign b4z.dado = dado;  assign b4z.push = push;  assign b4z.pop = pop;  assign b4z.clr_err = clr_err;
    assign b2.dado  = dado;  assign b2.push  = push;  assign b2.pop  = pop;  assign b2.clr_err  = clr_err;
    assign b10.dado = dado;  assign b10.push = push;  assign b10.pop = pop;  assign b10.clr_err = clr_err;
    assign b16.dado = dado;  assign b16.push = push;  assign b16.pop = pop;  assign b16.clr_err = clr_err;

    lifo_stack #(.WIDTH(32), .DEPTH(4),  .IGNORE_ZERO(0)) dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    lifo_stack #(.WIDTH(32), .DEPTH(4),  .IGNORE_ZERO(1)) dut4z (.clk(clk), .rst_n(rst_n), .bus(b4z));
    lifo_stack #(.WIDTH(32), .DEPTH(2),  .IGNORE_ZERO(0)) dut2  (.clk(clk), .rst_n(rst_n), .bus(b2));
    lifo_stack #(.WIDTH(32), .DEPTH(10), .IGNORE_ZERO(0)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));
    lifo_stack #(.WIDTH(32), .DEPTH(16), .IGNORE_ZERO(0)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output view of the DUT currently under soak.
    int          sel;
    logic [31:0] o_saida;
    int          o_count;
    logic        o_full, o_empty, o_ovf, o_udf;

    always_comb begin
        o_saida = b2.saida; o_count = int'(b2.count); o_full = b2.full;
        o_empty = b2.empty; o_ovf = b2.ovrflw; o_udf = b2.undrflw;
        if (sel == 1) begin
            o_saida = b10.saida; o_count = int'(b10.count); o_full = b10.full;
            o_empty = b10.empty; o_ovf = b10.ovrflw; o_udf = b10.undrflw;
        end else if (sel == 2) begin
            o_saida = b16.saida; o_count = int'(b16.count); o_full = b16.full;
            o_empty = b16.empty; o_ovf = b16.ovrflw; o_udf = b16.undrflw;
        end
    end

    // One clocked operation; outputs are inspected 1 time unit after the edge.
    task automatic step(input logic [31:0] d, input logic pu, input logic po, input logic ce);
        dado = d; push = pu; pop = po; clr_err = ce;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step(32'h0, 1'b0, 1'b0, 1'b0);
        checks++; if (b4.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", b4.count); end
        checks++; if (b4.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", b4.empty); end
        checks++; if (b4.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", b4.full); end
        checks++; if (b4.saida !== 32'h0) begin errors++; $display("FAIL reset_saida: got %h want 0", b4.saida); end
        checks++; if ({b4.ovrflw, b4.undrflw} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {b4.ovrflw, b4.undrflw}); end
    endtask

    task automatic test_push_pop();
        do_reset();
        step(32'h11, 1'b1, 1'b0, 1'b0);
        step(32'h22, 1'b1, 1'b0, 1'b0);
        step(32'h33, 1'b1, 1'b0, 1'b0);
        checks++; if (b4.count !== 3'd3) begin errors++; $display("FAIL push3_count: got %0d want 3", b4.count); end
        checks++; if (b4.saida !== 32'h33) begin errors++; $display("FAIL push3_saida: got %h want 33", b4.saida); end
        step(32'h0, 1'b0, 1'b1, 1'b0);
        checks++; if (b4.saida !== 32'h22) begin errors++; $display("FAIL pop1_saida: got %h want 22", b4.saida); end
        step(32'h0, 1'b0, 1'b1, 1'b0);
        checks++; if (b4.saida !== 32'h11) begin errors++; $display("FAIL pop2_saida: got %h want 11", b4.saida); end
        checks++; if (b4.count !== 3'd1) begin errors++; $display("FAIL pop2_count: got %0d want 1", b4.count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) step(32'h40 + 32'(i), 1'b1, 1'b0, 1'b0);
        checks++; if (b4.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", b4.full); end
        step(32'h55, 1'b1, 1'b0, 1'b0);
        checks++; if (b4.count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", b4.count); end
        checks++; if (b4.saida !== 32'h44) begin errors++; $display("FAIL ovf_saida: got %h want 44", b4.saida); end
        checks++; if (b4.ovrflw !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", b4.ovrflw); end
        step(32'h66, 1'b1, 1'b1, 1'b0);
        checks++; if (b4.saida !== 32'h66) begin errors++; $display("FAIL repl_full_saida: got %h want 66", b4.saida); end
        checks++; if (b4.count !== 3'd4) begin errors++; $display("FAIL repl_full_count: got %0d want 4", b4.count); end
        checks++; if (b4.undrflw !== 1'b0) begin errors++; $display("FAIL repl_full_udf: got %b want 0", b4.undrflw); end
        step(32'h0, 1'b0, 1'b1, 1'b0);
        checks++; if (b4.saida !== 32'h43) begin errors++; $display("FAIL pop_after_repl_saida: got %h want 43", b4.saida); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(32'h0, 1'b0, 1'b1, 1'b0);
        checks++; if (b4.undrflw !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b want 1", b4.undrflw); end
        checks++; if (b4.count !== 3'd0) begin errors++; $display("FAIL udf_count: got %0d want 0", b4.count); end
        checks++; if (b4.ovrflw !== 1'b0) begin errors++; $display("FAIL udf_ovf: got %b want 0", b4.ovrflw); end
        step(32'h77, 1'b1, 1'b1, 1'b0);
        checks++; if (b4.count !== 3'd1) begin errors++; $display("FAIL repl_empty_count: got %0d want 1", b4.count); end
        checks++; if (b4.saida !== 32'h77) begin errors++; $display("FAIL repl_empty_saida: got %h want 77", b4.saida); end
        checks++; if (b4.undrflw !== 1'b1) begin errors++; $display("FAIL repl_empty_udf: got %b want 1", b4.undrflw); end
        step(32'h0, 1'b0, 1'b0, 1'b1);
        checks++; if ({b4.ovrflw, b4.undrflw} !== 2'b00) begin errors++; $display("FAIL clr_flags: got %b want 00", {b4.ovrflw, b4.undrflw}); end
        checks++; if (b4.count !== 3'd1) begin errors++; $display("FAIL clr_count: got %0d want 1", b4.count); end
        step(32'h0, 1'b0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b1);
        checks++; if (b4.undrflw !== 1'b1) begin errors++; $display("FAIL clr_vs_udf: got %b want 1", b4.undrflw); end
    endtask

    task automatic test_ignore_zero();
        do_reset();
        step(32'hA, 1'b1, 1'b0, 1'b0);
        step(32'hB, 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (b4z.count !== 3'd2) begin errors++; $display("FAIL iz_push0_count: got %0d want 2", b4z.count); end
        checks++; if (b4z.saida !== 32'hB) begin errors++; $display("FAIL iz_push0_saida: got %h want b", b4z.saida); end
        checks++; if (b4.count !== 3'd3) begin errors++; $display("FAIL nz_push0_count: got %0d want 3", b4.count); end
        checks++; if (b4.saida !== 32'h0 || b4.empty !== 1'b0) begin errors++; $display("FAIL nz_push0_top: got saida=%h empty=%b want 0/0", b4.saida, b4.empty); end
        step(32'h0, 1'b1, 1'b1, 1'b0);
        checks++; if (b4z.count !== 3'd1) begin errors++; $display("FAIL iz_repl0_count: got %0d want 1", b4z.count); end
        checks++; if (b4z.saida !== 32'hA) begin errors++; $display("FAIL iz_repl0_saida: got %h want a", b4z.saida); end
        checks++; if (b4.count !== 3'd3) begin errors++; $display("FAIL nz_repl0_count: got %0d want 3", b4.count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 5; i++) step(32'(i), 1'b1, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b0);
        checks++; if (b4.count !== 3'd3 || b4.ovrflw !== 1'b1) begin errors++; $display("FAIL pre_rst_state: got count=%0d ovf=%b want 3/1", b4.count, b4.ovrflw); end
        rst_n = 1'b0;
        step(32'h9, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        checks++; if (b4.count !== 3'd0 || b4.empty !== 1'b1) begin errors++; $display("FAIL mid_rst_count: got count=%0d empty=%b want 0/1", b4.count, b4.empty); end
        checks++; if ({b4.ovrflw, b4.undrflw} !== 2'b00) begin errors++; $display("FAIL mid_rst_flags: got %b want 00", {b4.ovrflw, b4.undrflw}); end
        step(32'h0, 1'b0, 1'b0, 1'b0);
        checks++; if (b4.count !== 3'd0 || b4.saida !== 32'h0) begin errors++; $display("FAIL post_rst_idle: got count=%0d saida=%h want 0/0", b4.count, b4.saida); end
    endtask

    task automatic test_random_soak();
        int          depths [3] = '{2, 10, 16};
        logic [31:0] q [$];
        logic        m_ovf, m_udf, pu, po, ce;
        logic [31:0] d, exp_top;
        int          bad;
        for (int p = 0; p < 3; p++) begin
            sel = p;
            do_reset();
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0;
            bad = 0;
            for (int i = 0; i < 400; i++) begin
                pu = ($urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 30));
                po = ($urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 75));
                ce = ($urandom_range(0, 15) == 0);
                d  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                step(d, pu, po, ce);
                if (ce) begin m_ovf = 1'b0; m_udf = 1'b0; end
                if (pu && po) begin
                    if (q.size() == 0) begin q.push_back(d); m_udf = 1'b1; end
                    else q[q.size() - 1] = d;
                end else if (pu) begin
                    if (q.size() == depths[p]) m_ovf = 1'b1;
                    else q.push_back(d);
                end else if (po) begin
                    if (q.size() == 0) m_udf = 1'b1;
                    else void'(q.pop_back());
                end
                exp_top = (q.size() > 0) ? q[q.size() - 1] : 32'h0;
                checks++;
                if (o_count !== q.size() || o_saida !== exp_top || o_full !== (q.size() == depths[p]) ||
                    o_empty !== (q.size() == 0) || o_ovf !== m_ovf || o_udf !== m_udf) begin
                    errors++;
                    if (bad < 5)
                        $display("FAIL soak_d%0d_cyc%0d: got cnt=%0d top=%h f=%b e=%b o=%b u=%b want cnt=%0d top=%h o=%b u=%b",
                                 depths[p], i, o_count, o_saida, o_full, o_empty, o_ovf, o_udf,
                                 q.size(), exp_top, m_ovf, m_udf);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; dado = '0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; sel = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_ignore_zero();
        test_reset_mid();
        test_random_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
